// File: rtl/fifo_frame_tx_if.sv
// Sample-FIFO read port seen by the frame transmitter.
// master = transmitter side, slave = FIFO side.
interface fifo_frame_tx_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_frame_tx.sv
// Pops one 24-bit sample and sends it as a 6-byte 8N1 UART frame:
// HEADER, seq, D[23:16], D[15:8], D[7:0], checksum.
module fifo_frame_tx #(
    parameter int          CLK_DIV    = 87,
    parameter int          DATA_WIDTH = 24,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    fifo_frame_tx_if.master       ff,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            seq
);

    localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [2:0]            byte_q, byte_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            chk_q, chk_d;
    logic [7:0]            seq_q, seq_d;
    logic                  tx_q, tx_d;
    logic                  armed_q;
    logic                  rd_en;
    logic [7:0]            cur_byte;
    logic [7:0]            lat_chk;
    logic                  cnt_zero;

    assign cnt_zero = (cnt_q == 16'd0);

    assign lat_chk = seq_q
                   + ff.fifo_data_out[23:16]
                   + ff.fifo_data_out[15:8]
                   + ff.fifo_data_out[7:0];

    always_comb begin
        case (byte_q)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = seq_q;
            3'd2:    cur_byte = word_q[23:16];
            3'd3:    cur_byte = word_q[15:8];
            3'd4:    cur_byte = word_q[7:0];
            default: cur_byte = chk_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        word_d     = word_q;
        chk_d      = chk_q;
        seq_d      = seq_q;
        tx_d       = tx_q;
        rd_en      = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                // armed_q holds off the first pop until a clock edge after reset
                if (armed_q && enable && !ff.fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LATCH;
            end
            LATCH: begin
                word_d  = ff.fifo_data_out;
                chk_d   = lat_chk;
                byte_d  = 3'd0;
                bit_d   = 4'd0;
                cnt_d   = BIT_LAST;
                tx_d    = 1'b0;
                state_d = START;
            end
            START: begin
                if (cnt_zero) begin
                    cnt_d   = BIT_LAST;
                    bit_d   = 4'd0;
                    tx_d    = cur_byte[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    cnt_d = BIT_LAST;
                    if (bit_q == 4'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = cur_byte[bit_q[2:0] + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    if (byte_q == 3'd5) begin
                        frame_done = 1'b1;
                        seq_d      = seq_q + 8'd1;
                        state_d    = IDLE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        cnt_d   = BIT_LAST;
                        tx_d    = 1'b0;
                        state_d = START;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            chk_q   <= '0;
            seq_q   <= '0;
            tx_q    <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            chk_q   <= chk_d;
            seq_q   <= seq_d;
            tx_q    <= tx_d;
            armed_q <= 1'b1;
        end
    end

    assign ff.fifo_rd_en = rd_en;
    assign tx            = tx_q;
    assign busy          = (state_q != IDLE);
    assign seq           = seq_q;

endmodule

// File: tb/tb_fifo_frame_tx.sv
// Directed bench for fifo_frame_tx at CLK_DIV=4: a queue-backed FIFO model
// feeds the DUT and a UART receiver decodes tx into bytes.
module tb_fifo_frame_tx;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [7:0] seq;

    fifo_frame_tx_if ff ();

    fifo_frame_tx #(
        .CLK_DIV(DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ff         (ff),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .seq        (seq)
    );

    always #5 clk = ~clk;

    logic [23:0] words[$];
    int          wr_cnt = 0;
    int          rd_ptr = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          viol = 0;
    logic        rd_prev = 1'b0;
    int          rd_times[$];
    int          done_times[$];
    int          total = 0;
    int          passed = 0;

    assign ff.fifo_empty = (rd_ptr >= wr_cnt);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ff.fifo_rd_en) begin
            if (ff.fifo_empty) viol <= viol + 1;
            if (rd_ptr < wr_cnt) ff.fifo_data_out <= words[rd_ptr];
            rd_ptr <= rd_ptr + 1;
            rd_times.push_back(cyc);
        end
        if (ff.fifo_rd_en && rd_prev) viol <= viol + 1;
        rd_prev <= ff.fifo_rd_en;
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_times.push_back(cyc);
        end
    end

    task automatic push(input logic [23:0] w);
        words.push_back(w);
        wr_cnt = wr_cnt + 1;
    endtask

    task automatic get_byte(output logic [7:0] b);
        int n;
        b = 'x;
        n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) return;
        repeat (DIV / 2) @(negedge clk);
        if (tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        if (tx !== 1'b1) b = 'x;
    endtask

    task automatic recv_frame(output logic [5:0][7:0] f);
        for (int i = 0; i < 6; i++) get_byte(f[i]);
    endtask

    task automatic wait_done(input int target, input int budget,
                             output bit ok);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt >= target);
    endtask

    task automatic test_reset;
        enable = 1'b1;
        push(24'h123456);
        #12;
        total++;
        if ({tx, busy, frame_done, ff.fifo_rd_en} !== 4'b1000) begin
            $display("FAIL reset_outputs: got %b want 1000",
                     {tx, busy, frame_done, ff.fifo_rd_en});
        end else passed++;
        total++;
        if (seq !== 8'h00) $display("FAIL reset_seq: got %h want 00", seq);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (ff.fifo_rd_en !== 1'b0) begin
            $display("FAIL release_no_pop: got %b want 0", ff.fifo_rd_en);
        end else passed++;
    endtask

    task automatic test_single;
        logic [5:0][7:0] f, exp;
        int d0, p0;
        exp = {8'h9C, 8'h56, 8'h34, 8'h12, 8'h00, 8'hA5};
        d0 = done_cnt;
        p0 = rd_ptr;
        recv_frame(f);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (f[i] !== exp[i]) begin
                $display("FAIL single_byte%0d: got %h want %h", i, f[i], exp[i]);
            end else passed++;
        end
        repeat (6) @(negedge clk);
        total++;
        if (done_cnt - d0 !== 1) begin
            $display("FAIL single_done: got %0d want 1", done_cnt - d0);
        end else passed++;
        total++;
        if (rd_ptr - p0 !== 1) begin
            $display("FAIL single_pops: got %0d want 1", rd_ptr - p0);
        end else passed++;
        total++;
        if (seq !== 8'h01) $display("FAIL single_seq: got %h want 01", seq);
        else passed++;
        total++;
        if (done_times[$] - rd_times[$] !== 242) begin
            $display("FAIL single_len: got %0d want 242",
                     done_times[$] - rd_times[$]);
        end else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [5:0][7:0] f1, f2, e1, e2;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        e1 = {8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA5};
        e2 = {8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hA5};
        push(24'h000001);
        push(24'hFFFFFF);
        recv_frame(f1);
        recv_frame(f2);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (f1[i] !== e1[i]) begin
                $display("FAIL b2b_f1_byte%0d: got %h want %h", i, f1[i], e1[i]);
            end else passed++;
            total++;
            if (f2[i] !== e2[i]) begin
                $display("FAIL b2b_f2_byte%0d: got %h want %h", i, f2[i], e2[i]);
            end else passed++;
        end
        repeat (6) @(negedge clk);
        total++;
        if (rd_times[$] - done_times[$-1] !== 1) begin
            $display("FAIL b2b_gap: got %0d want 1",
                     rd_times[$] - done_times[$-1]);
        end else passed++;
        total++;
        if (seq !== 8'h02) $display("FAIL b2b_seq: got %h want 02", seq);
        else passed++;
    endtask

    task automatic test_seq_wrap;
        logic [5:0][7:0] f, exp;
        int d0;
        bit ok;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 255; i++) push(24'h000000);
        wait_done(d0 + 255, 255 * 250, ok);
        total++;
        if (!ok) $display("FAIL wrap_timeout: got %0d frames want 255",
                          done_cnt - d0);
        else passed++;
        repeat (4) @(negedge clk);
        total++;
        if (seq !== 8'hFF) $display("FAIL wrap_preload: got %h want ff", seq);
        else passed++;
        exp = {8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hA5};
        push(24'h000000);
        recv_frame(f);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (f[i] !== exp[i]) begin
                $display("FAIL wrap_byte%0d: got %h want %h", i, f[i], exp[i]);
            end else passed++;
        end
        repeat (6) @(negedge clk);
        total++;
        if (seq !== 8'h00) $display("FAIL wrap_seq: got %h want 00", seq);
        else passed++;
    endtask

    task automatic test_empty_idle;
        int bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ff.fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0)
                bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL empty_idle: got %0d bad cycles want 0", bad);
        else passed++;
    endtask

    task automatic test_enable_drop;
        logic [5:0][7:0] f, exp;
        int p0, d0;
        exp = {8'h67, 8'hEF, 8'hCD, 8'hAB, 8'h00, 8'hA5};
        p0 = rd_ptr;
        d0 = done_cnt;
        push(24'hABCDEF);
        push(24'h654321);
        fork
            recv_frame(f);
            begin
                repeat (95) @(negedge clk);
                enable = 1'b0;
            end
        join
        for (int i = 0; i < 6; i++) begin
            total++;
            if (f[i] !== exp[i]) begin
                $display("FAIL drop_byte%0d: got %h want %h", i, f[i], exp[i]);
            end else passed++;
        end
        repeat (50) @(negedge clk);
        total++;
        if (rd_ptr - p0 !== 1) begin
            $display("FAIL drop_pops: got %0d want 1", rd_ptr - p0);
        end else passed++;
        total++;
        if (done_cnt - d0 !== 1) begin
            $display("FAIL drop_done: got %0d want 1", done_cnt - d0);
        end else passed++;
        total++;
        if ({busy, ff.fifo_empty} !== 2'b00) begin
            $display("FAIL drop_idle: got %b want 00", {busy, ff.fifo_empty});
        end else passed++;
    endtask

    task automatic test_reset_mid;
        logic [5:0][7:0] f, exp;
        logic [7:0] b0, b1, b2;
        int p0;
        p0 = rd_ptr;
        enable = 1'b1;
        get_byte(b0);
        get_byte(b1);
        get_byte(b2);
        total++;
        if ({b0, b1, b2} !== 24'hA50165) begin
            $display("FAIL mid_prefix: got %h want a50165", {b0, b1, b2});
        end else passed++;
        repeat (6) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++;
        if ({tx, busy, frame_done, ff.fifo_rd_en} !== 4'b1000) begin
            $display("FAIL mid_async: got %b want 1000",
                     {tx, busy, frame_done, ff.fifo_rd_en});
        end else passed++;
        total++;
        if (seq !== 8'h00) $display("FAIL mid_seq: got %h want 00", seq);
        else passed++;
        push(24'h0F0F0F);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp = {8'h2D, 8'h0F, 8'h0F, 8'h0F, 8'h00, 8'hA5};
        recv_frame(f);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (f[i] !== exp[i]) begin
                $display("FAIL mid_byte%0d: got %h want %h", i, f[i], exp[i]);
            end else passed++;
        end
        repeat (6) @(negedge clk);
        total++;
        if (rd_ptr - p0 !== 2) begin
            $display("FAIL mid_pops: got %0d want 2", rd_ptr - p0);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_seq_wrap();
        test_empty_idle();
        test_enable_drop();
        test_reset_mid();
        total++;
        if (viol !== 0) $display("FAIL rd_en_rules: got %0d want 0", viol);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
